// File: rtl/xpe_pipe.sv
// xpe_pipe: 3-stage NPE post-processing (bias add, rounding shift, activation, saturation) with valid/ready.
// Build option: define XPE_PIPE_LEAKY_EN for leaky ReLU in mode 3; without it mode 3 behaves as mode 2.
module xpe_pipe #(
  parameter int unsigned LANES       = 32,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned BIAS_W      = 16,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned CH_W        = 8,
  parameter int unsigned LEAKY_SHIFT = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cfg_we,
  input  logic [1:0]              i_cfg_mode,
  input  logic [4:0]              i_cfg_shift,
  input  logic [CH_W-1:0]         i_cfg_ch_num,
  input  logic                    i_bias_we,
  input  logic [CH_W-1:0]         i_bias_addr,
  input  logic [LANES*BIAS_W-1:0] i_bias_wdata,
  input  logic [LANES*ACC_W-1:0]  i_s_dat,
  input  logic                    i_s_vld,
  output logic                    o_s_rdy,
  output logic [LANES*OUT_W-1:0]  o_m_dat,
  output logic                    o_m_vld,
  input  logic                    i_m_rdy,
  output logic [CH_W-1:0]         o_ch_idx,
  output logic                    o_busy,
  output logic                    o_sat_flag
);
  localparam int unsigned SW    = ACC_W + 1;
  localparam int unsigned RW    = ACC_W + 34;  // headroom for the rounding add at shifts up to 31
  localparam int unsigned DEPTH = 2 ** CH_W;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (OUT_W - 1)));

  if (BIAS_W > ACC_W || LEAKY_SHIFT >= SW) begin : g_param_check
    $error("xpe_pipe: BIAS_W must not exceed ACC_W and LEAKY_SHIFT must be below ACC_W+1");
  end

  // Bias add and round-half-up arithmetic shift; bypass passes the raw accumulator through.
  function automatic logic [SW-1:0] f_requant(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [BIAS_W-1:0] b,
    input logic [4:0]               s,
    input logic [1:0]               mode
  );
    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] half;
    logic signed [RW-1:0] res;
    sum  = RW'(a) + RW'(b);
    half = RW'(1) << (s - 5'd1);
    res  = (s == 5'd0) ? sum : ((sum + half) >>> s);
    return (mode == 2'd0) ? SW'(a) : SW'(res);
  endfunction

  // Activation then saturation; returns {clipped, lane}.
  function automatic logic [OUT_W:0] f_act_sat(
    input logic signed [SW-1:0] r,
    input logic [1:0]           mode
  );
    logic signed [SW-1:0] v;
    v = r;
    if (mode[1] && r[SW-1]) begin
`ifdef XPE_PIPE_LEAKY_EN
      v = mode[0] ? (r >>> LEAKY_SHIFT) : '0;
`else
      v = '0;
`endif
    end
    if (mode == 2'd0) return {1'b0, r[OUT_W-1:0]};
    if (v > SAT_MAX)  return {1'b1, SAT_MAX[OUT_W-1:0]};
    if (v < SAT_MIN)  return {1'b1, SAT_MIN[OUT_W-1:0]};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic [LANES*BIAS_W-1:0] r_bias_mem [DEPTH];
  logic [1:0]              r_mode;
  logic [4:0]              r_shift;
  logic [CH_W-1:0]         r_ch_num;
  logic [CH_W-1:0]         r_ch_cnt;
  logic                    r_s1_vld;
  logic [LANES*ACC_W-1:0]  r_s1_dat;
  logic [LANES*BIAS_W-1:0] r_s1_bias;
  logic [CH_W-1:0]         r_s1_ch;
  logic                    r_s2_vld;
  logic [LANES*SW-1:0]     r_s2_r;
  logic [CH_W-1:0]         r_s2_ch;

  logic                    w_en;
  logic                    w_acc;
  logic                    w_cfg_ld;
  logic [CH_W-1:0]         w_ch_max;
  logic [LANES*SW-1:0]     w_s2_r;
  logic [LANES*OUT_W-1:0]  w_s3_dat;
  logic [OUT_W:0]          w_s3_lane;
  logic                    w_s3_clip;

  assign w_en     = !(o_m_vld && !i_m_rdy);
  assign w_acc    = i_s_vld && w_en;
  assign w_cfg_ld = i_cfg_we && !o_busy;
  assign w_ch_max = (r_ch_num == '0) ? '0 : r_ch_num - CH_W'(1);
  assign o_s_rdy  = w_en;
  assign o_busy   = r_s1_vld | r_s2_vld | o_m_vld;

  always_comb begin
    w_s2_r    = '0;
    w_s3_dat  = '0;
    w_s3_lane = '0;
    w_s3_clip = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_s2_r[l*SW +: SW] = f_requant(r_s1_dat[l*ACC_W +: ACC_W], r_s1_bias[l*BIAS_W +: BIAS_W],
                                     r_shift, r_mode);
      w_s3_lane = f_act_sat(r_s2_r[l*SW +: SW], r_mode);
      w_s3_dat[l*OUT_W +: OUT_W] = w_s3_lane[OUT_W-1:0];
      w_s3_clip = w_s3_clip | w_s3_lane[OUT_W];
    end
  end

  // Bias table has no reset; writes are independent of pipeline flow.
  always_ff @(posedge i_clk) begin
    if (i_bias_we) r_bias_mem[i_bias_addr] <= i_bias_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode   <= '0;
      r_shift  <= '0;
      r_ch_num <= '0;
      r_ch_cnt <= '0;
    end else if (w_cfg_ld) begin
      r_mode   <= i_cfg_mode;
      r_shift  <= i_cfg_shift;
      r_ch_num <= i_cfg_ch_num;
      r_ch_cnt <= '0;
    end else if (w_acc) begin
      r_ch_cnt <= (r_ch_cnt >= w_ch_max) ? '0 : r_ch_cnt + CH_W'(1);
    end
  end

  // All three stages advance together on w_en; bubbles travel as cleared valids.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_dat   <= '0;
      r_s1_bias  <= '0;
      r_s1_ch    <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_r     <= '0;
      r_s2_ch    <= '0;
      o_m_vld    <= 1'b0;
      o_m_dat    <= '0;
      o_ch_idx   <= '0;
      o_sat_flag <= 1'b0;
    end else begin
      if (w_cfg_ld) o_sat_flag <= 1'b0;
      if (w_en) begin
        r_s1_vld <= i_s_vld;
        if (i_s_vld) begin
          r_s1_dat  <= i_s_dat;
          r_s1_bias <= r_bias_mem[r_ch_cnt];
          r_s1_ch   <= r_ch_cnt;
        end
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_r  <= w_s2_r;
          r_s2_ch <= r_s1_ch;
        end
        o_m_vld <= r_s2_vld;
        if (r_s2_vld) begin
          o_m_dat  <= w_s3_dat;
          o_ch_idx <= r_s2_ch;
          if (w_s3_clip) o_sat_flag <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_xpe_pipe.sv
// Scoreboard bench for xpe_pipe: a lane-arithmetic reference model predicts each accepted beat.
module tb_xpe_pipe;
  localparam int unsigned LANES = 32;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned BIAS_W = 16;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned CH_W = 8;
  localparam int LEAKY_DIV = 8;
  localparam int unsigned IN_W = LANES * ACC_W;
  localparam int unsigned OB_W = LANES * OUT_W;
  localparam int unsigned BR_W = LANES * BIAS_W;

  typedef struct packed {
    logic [OB_W-1:0] dat;
    logic [CH_W-1:0] ch;
  } exp_t;

  logic            i_clk, i_rst, i_cfg_we, i_bias_we, i_s_vld, i_m_rdy;
  logic [1:0]      i_cfg_mode;
  logic [4:0]      i_cfg_shift;
  logic [CH_W-1:0] i_cfg_ch_num, i_bias_addr, o_ch_idx;
  logic [BR_W-1:0] i_bias_wdata;
  logic [IN_W-1:0] i_s_dat;
  logic [OB_W-1:0] o_m_dat;
  logic            o_s_rdy, o_m_vld, o_busy, o_sat_flag;

  xpe_pipe dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_we(i_cfg_we), .i_cfg_mode(i_cfg_mode),
    .i_cfg_shift(i_cfg_shift), .i_cfg_ch_num(i_cfg_ch_num), .i_bias_we(i_bias_we),
    .i_bias_addr(i_bias_addr), .i_bias_wdata(i_bias_wdata), .i_s_dat(i_s_dat),
    .i_s_vld(i_s_vld), .o_s_rdy(o_s_rdy), .o_m_dat(o_m_dat), .o_m_vld(o_m_vld),
    .i_m_rdy(i_m_rdy), .o_ch_idx(o_ch_idx), .o_busy(o_busy), .o_sat_flag(o_sat_flag)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  exp_t            sb[$];
  logic [BR_W-1:0] bias_tab [256];
  int              m_mode, m_shift, m_chnum, m_ch;
  logic            m_sat;
  int              errors, checks, n_out;
  logic            last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // One lane as the arithmetic rules state it; returns {clipped, value}.
  function automatic logic [OUT_W:0] ref_lane(input longint x, input longint b);
    longint r;
    if (m_mode == 0) return {1'b0, OUT_W'(x)};
    r = x + b;
    if (m_shift > 0) r = floor_div(r + (longint'(1) << (m_shift - 1)), longint'(1) << m_shift);
    if (r < 0 && m_mode >= 2) begin
`ifdef XPE_PIPE_LEAKY_EN
      r = (m_mode == 3) ? floor_div(r, LEAKY_DIV) : 0;
`else
      r = 0;
`endif
    end
    if (r > 127)  return {1'b1, 8'h7f};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, OUT_W'(r)};
  endfunction

  function automatic logic [OB_W:0] ref_beat(input logic [IN_W-1:0] d, input logic [BR_W-1:0] b);
    logic [OB_W:0]  res;
    logic [OUT_W:0] l;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      l = ref_lane(longint'($signed(d[i*ACC_W +: ACC_W])), longint'($signed(b[i*BIAS_W +: BIAS_W])));
      res[i*OUT_W +: OUT_W] = l[OUT_W-1:0];
      if (l[OUT_W]) res[OB_W] = 1'b1;
    end
    return res;
  endfunction

  function automatic logic [IN_W-1:0] lanes(input int v);
    logic [IN_W-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*ACC_W +: ACC_W] = 16'(v);
    return d;
  endfunction

  function automatic logic [IN_W-1:0] rand_row();
    logic [IN_W-1:0] d;
    for (int i = 0; i < IN_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock of stimulus; an accepted beat pushes its predicted result.
  task automatic step(input logic vld, input logic [IN_W-1:0] dat, input logic mrdy);
    logic [OB_W:0] rb;
    exp_t          e;
    @(posedge i_clk); #2;
    i_s_vld = vld; i_s_dat = dat; i_m_rdy = mrdy;
    #1;
    last_acc = vld && o_s_rdy;
    if (last_acc) begin
      rb    = ref_beat(dat, bias_tab[m_ch]);
      e.dat = rb[OB_W-1:0];
      e.ch  = CH_W'(m_ch);
      if (rb[OB_W]) m_sat = 1'b1;
      sb.push_back(e);
      m_ch = (m_ch + 1 >= ((m_chnum == 0) ? 1 : m_chnum)) ? 0 : m_ch + 1;
    end
  endtask

  task automatic send(input logic [IN_W-1:0] dat);
    int n;
    n = 0;
    do begin step(1'b1, dat, 1'b1); n++; end while (!last_acc && n < 50);
    if (!last_acc) begin checks++; errors++; $display("FAIL send_timeout accepted=0 expected=1"); end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((o_busy || sb.size() != 0) && n < 100) begin step(1'b0, '0, 1'b1); n++; end
    checks++;
    if (o_busy || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout busy=%0b pending=%0d expected busy=0 pending=0", o_busy, sb.size());
    end
  endtask

  task automatic cfg(input int mode, input int shift, input int chnum);
    drain();
    @(posedge i_clk); #2;
    i_s_vld = 1'b0; i_cfg_we = 1'b1;
    i_cfg_mode = 2'(mode); i_cfg_shift = 5'(shift); i_cfg_ch_num = CH_W'(chnum);
    m_mode = mode; m_shift = shift; m_chnum = chnum; m_ch = 0; m_sat = 1'b0;
    @(posedge i_clk); #2;
    i_cfg_we = 1'b0;
  endtask

  task automatic bias_write(input int addr, input logic [BR_W-1:0] row);
    @(posedge i_clk); #2;
    i_s_vld = 1'b0; i_bias_we = 1'b1; i_bias_addr = CH_W'(addr); i_bias_wdata = row;
    bias_tab[addr] = row;
    @(posedge i_clk); #2;
    i_bias_we = 1'b0;
  endtask

  // Monitor: handshake seen mid-cycle completes at the next rising edge.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst && o_m_vld && i_m_rdy) begin
      checks++;
      n_out++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output ch=%0d data=%h expected no beat", o_ch_idx, o_m_dat);
      end else begin
        e = sb.pop_front();
        if (o_m_dat !== e.dat || o_ch_idx !== e.ch) begin
          errors++;
          $display("FAIL beat ch=%0d data=%h expected ch=%0d data=%h", o_ch_idx, o_m_dat, e.ch, e.dat);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] beats [8];
    logic [OB_W-1:0] held;
    int lat, i, c, n0, mode, sh, cn;
    errors = 0; checks = 0; n_out = 0;
    i_rst = 1'b1; i_cfg_we = 1'b0; i_cfg_mode = '0; i_cfg_shift = '0; i_cfg_ch_num = '0;
    i_bias_we = 1'b0; i_bias_addr = '0; i_bias_wdata = '0; i_s_dat = '0; i_s_vld = 1'b0; i_m_rdy = 1'b1;
    m_mode = 0; m_shift = 0; m_chnum = 0; m_ch = 0; m_sat = 1'b0;
    for (int k = 0; k < 256; k++) bias_tab[k] = '0;
    repeat (2) @(posedge i_clk);
    #3;
    chk("rst_m_vld", 64'(o_m_vld), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_sat", 64'(o_sat_flag), 0);
    chk("rst_s_rdy", 64'(o_s_rdy), 1);
    chk("rst_ch_idx", 64'(o_ch_idx), 0);
    chk("rst_m_dat_lo", o_m_dat[63:0], 0);
    @(posedge i_clk); #2;
    i_rst = 1'b0;

    // Bias 8, shift 4: 100 -> 7, -100 -> -6, three-cycle latency
    cfg(1, 4, 1);
    bias_write(0, lanes(8));
    send(lanes(100));
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, '0, 1'b1);
      if (o_m_vld && lat == 0) lat = k;
    end
    chk("latency", 64'(lat), 3);
    send(lanes(-100));
    drain();
    chk("sat_mode1_small", 64'(o_sat_flag), 0);

    // Saturation both ways, sticky flag cleared by reconfiguration
    cfg(1, 2, 1);
    bias_write(0, '0);
    send(lanes(5000));
    send(lanes(-5000));
    drain();
    chk("sat_set", 64'(o_sat_flag), 1);
    step(1'b0, '0, 1'b1);
    chk("sat_sticky", 64'(o_sat_flag), 1);
    cfg(1, 2, 1);
    step(1'b0, '0, 1'b1);
    chk("sat_cleared", 64'(o_sat_flag), 0);

    // Channel rotation over three bias rows
    cfg(1, 4, 3);
    bias_write(0, lanes(0));
    bias_write(1, lanes(16));
    bias_write(2, lanes(32));
    for (int k = 0; k < 7; k++) send(lanes(0));
    drain();

    // Five-cycle output stall in the middle of an 8-beat stream
    cfg(1, 3, 4);
    for (int k = 0; k < 4; k++) bias_write(k, rand_row());
    for (int k = 0; k < 8; k++) beats[k] = rand_row();
    n0 = n_out; i = 0; c = 0; held = '0;
    while (i < 8 && c < 60) begin
      step(1'b1, beats[i], !(c >= 4 && c < 9));
      if (last_acc) i++;
      if (c >= 4 && c < 9) chk("stall_s_rdy", 64'(o_s_rdy), 0);
      if (c == 4) held = o_m_dat;
      if (c == 8) chk("stall_hold", 64'(o_m_dat == held), 1);
      c++;
    end
    drain();
    chk("stream_count", 64'(n_out - n0), 8);

    // Negative input under both ReLU flavours
    cfg(3, 0, 1);
    bias_write(0, '0);
    send(lanes(-64));
    drain();
    cfg(2, 0, 1);
    send(lanes(-64));
    drain();

    // Randomised passes over mode, shift, channel count, bias and flow control
    for (int p = 0; p < 8; p++) begin
      mode = $urandom_range(0, 3);
      sh   = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 10);
      cn   = $urandom_range(0, 5);
      cfg(mode, sh, cn);
      for (int r = 0; r < ((cn == 0) ? 1 : cn); r++) bias_write(r, rand_row());
      for (int k = 0; k < 40; k++) step($urandom_range(0, 9) < 7, rand_row(), $urandom_range(0, 3) != 0);
      drain();
      chk("rand_sat", 64'(o_sat_flag), 64'(m_sat));
    end

    // Asynchronous reset while the output is stalled and saturated
    cfg(1, 0, 1);
    for (int k = 0; k < 3; k++) send(lanes(5000));
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0);
    chk("pre_rst_vld", 64'(o_m_vld), 1);
    chk("pre_rst_sat", 64'(o_sat_flag), 1);
    @(posedge i_clk); #4;
    i_rst = 1'b1;
    #1;
    chk("midrst_m_vld", 64'(o_m_vld), 0);
    chk("midrst_busy", 64'(o_busy), 0);
    chk("midrst_sat", 64'(o_sat_flag), 0);
    chk("midrst_s_rdy", 64'(o_s_rdy), 1);
    sb.delete();
    m_mode = 0; m_shift = 0; m_chnum = 0; m_ch = 0; m_sat = 1'b0;
    @(posedge i_clk); #2;
    i_rst = 1'b0; i_m_rdy = 1'b1;
    send(rand_row());
    send(rand_row());
    drain();
    chk("post_rst_sat", 64'(o_sat_flag), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
